// File: rtl/top.sv
// Accumulator CPU: 8-clock instruction cycle over a 32x8 unified memory.
// Each instruction takes eight clocks and there is no backpressure; halt freezes the phase counter until rst.
module memory (
  input  logic       clk,
  input  logic [4:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wr_dat,
  output logic [7:0] rd_dat
);
  reg [7:0] array [0:31];

  assign rd_dat = array[addr];

  always_ff @(posedge clk) begin
    if (wr_en) array[addr] <= wr_dat;
  end
endmodule

module top (
  input  logic clk,
  input  logic rst,
  output logic halt
);
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_t;

  phase_t     phase_q, phase_d;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [7:0] ac;
  logic [4:0] mem_addr;
  logic [7:0] mem_dat;
  logic       mem_wr_en;
  logic       zero;
  opcode_t    opcode;

  assign opcode    = opcode_t'(ir[7:5]);
  assign zero      = (ac == 8'd0);
  // First half of the cycle addresses the instruction, second half the operand.
  assign mem_addr  = phase_q[2] ? ir[4:0] : pc;
  assign mem_wr_en = !rst && (phase_q == STORE) && (opcode == OP_STO);

  memory memory_inst (
    .clk    (clk),
    .addr   (mem_addr),
    .wr_en  (mem_wr_en),
    .wr_dat (ac),
    .rd_dat (mem_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= INST_ADDR;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_t'(phase_q + 3'd1);
    halt    = 1'b0;
    if (phase_q == OP_ADDR && opcode == OP_HLT) begin
      halt    = 1'b1;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 5'd0;
      ir <= 8'd0;
      ac <= 8'd0;
    end else begin
      case (phase_q)
        INST_LOAD, IDLE: ir <= mem_dat;
        OP_ADDR: begin
          if (opcode != OP_HLT) pc <= pc + 5'd1;
        end
        ALU_OP: begin
          if (opcode == OP_SKZ && zero) pc <= pc + 5'd1;
          if (opcode == OP_JMP)         pc <= ir[4:0];
        end
        STORE: begin
          case (opcode)
            OP_ADD:  ac <= ac + mem_dat;
            OP_AND:  ac <= ac & mem_dat;
            OP_XOR:  ac <= ac ^ mem_dat;
            OP_LDA:  ac <= mem_dat;
            OP_JMP:  pc <= ir[4:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top.sv
// Bench for top: directed programs with fixed halt timing plus random programs against an ISA-level model.
module tb_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;

  top dut (.clk(clk), .rst(rst), .halt(halt));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prog  [32];
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_ac;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic clear_prog;
    foreach (prog[i]) prog[i] = 8'h00;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 32; i++) begin
      dut.memory_inst.array[i] = prog[i];
      m_mem[i] = prog[i];
    end
    m_pc = 5'd0;
    m_ac = 8'd0;
  endtask

  // One whole instruction at ISA level; reports HLT without changing state.
  task automatic m_step(output bit hlt);
    logic [7:0] w;
    logic [4:0] a;
    w = m_mem[m_pc];
    a = w[4:0];
    hlt = 1'b0;
    if (w[7:5] == 3'd0) begin
      hlt = 1'b1;
    end else begin
      m_pc = m_pc + 5'd1;
      case (w[7:5])
        3'd1: if (m_ac == 8'd0) m_pc = m_pc + 5'd1;
        3'd2: m_ac = m_ac + m_mem[a];
        3'd3: m_ac = m_ac & m_mem[a];
        3'd4: m_ac = m_ac ^ m_mem[a];
        3'd5: m_ac = m_mem[a];
        3'd6: m_mem[a] = m_ac;
        default: m_pc = a;
      endcase
    end
  endtask

  task automatic check_mem_all(input string tag);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s mem[%0d]", tag, i), 32'(dut.memory_inst.array[i]), 32'(m_mem[i]));
  endtask

  // Loads prog, resets, and checks halt just before and at the required clock count.
  task automatic run_directed(input string tag, input int n_halt);
    load_prog();
    do_reset();
    check_eq({tag, " halt@reset"}, 32'(halt), 32'd0);
    tick(n_halt - 1);
    check_eq({tag, " halt early"}, 32'(halt), 32'd0);
    tick(1);
    check_eq({tag, " halt set"}, 32'(halt), 32'd1);
  endtask

  initial begin
    bit hlt;
    int n_exec;

    // Reset state
    clear_prog();
    load_prog();
    rst = 1'b1;
    tick(1);
    check_eq("rst halt", 32'(halt), 32'd0);
    check_eq("rst pc", 32'(dut.pc), 32'd0);
    check_eq("rst ac", 32'(dut.ac), 32'd0);
    check_eq("rst ir", 32'(dut.ir), 32'd0);

    clear_prog();
    run_directed("hlt0", 3);

    clear_prog();
    prog[0] = 8'hE2; prog[1] = 8'hE2; prog[2] = 8'h00;
    run_directed("jmp", 11);

    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'hE2; prog[2] = 8'h00;
    run_directed("skz", 11);

    clear_prog();
    prog[0] = 8'hA7; prog[1] = 8'hC8; prog[2] = 8'hA8; prog[3] = 8'h20;
    prog[4] = 8'h00; prog[5] = 8'hE6; prog[6] = 8'h00;
    prog[7] = 8'h01; prog[8] = 8'h00;
    run_directed("sto", 35);
    check_eq("sto mem8", 32'(dut.memory_inst.array[8]), 32'h01);

    clear_prog();
    prog[0] = 8'hA9; prog[1] = 8'h4B; prog[2] = 8'h20; prog[3] = 8'h00;
    prog[4] = 8'h4B; prog[5] = 8'h20; prog[6] = 8'h00;
    prog[9] = 8'hFF; prog[11] = 8'h01;
    run_directed("add", 43);
    check_eq("add ac", 32'(dut.ac), 32'h01);

    for (int k = 0; k < 2; k++) begin
      clear_prog();
      prog[0] = 8'hAA; prog[1] = (k == 0) ? 8'h6B : 8'h8B; prog[2] = 8'h20;
      prog[3] = 8'hE5; prog[4] = 8'h00; prog[5] = (k == 0) ? 8'h6C : 8'h8C;
      prog[6] = 8'h20; prog[7] = 8'h00; prog[8] = 8'hE9; prog[9] = 8'h00;
      prog[10] = (k == 0) ? 8'hFF : 8'h55;
      prog[11] = (k == 0) ? 8'h01 : 8'h54;
      prog[12] = (k == 0) ? 8'hFE : 8'h01;
      run_directed((k == 0) ? "and" : "xor", 59);
    end

    // Reset during the STORE phase of a STO must suppress the write.
    clear_prog();
    prog[0] = 8'hA7; prog[1] = 8'hC8; prog[2] = 8'h00;
    prog[7] = 8'h5A; prog[8] = 8'h33;
    load_prog();
    do_reset();
    tick(14);
    check_eq("abort ac pre", 32'(dut.ac), 32'h5A);
    #1 rst = 1'b1;
    #1;
    check_eq("abort ac async", 32'(dut.ac), 32'd0);
    check_eq("abort pc async", 32'(dut.pc), 32'd0);
    tick(1);
    check_eq("abort mem8", 32'(dut.memory_inst.array[8]), 32'h33);
    check_eq("abort ac held", 32'(dut.ac), 32'd0);
    rst = 1'b0;
    tick(1);
    check_eq("abort phase1", 32'(dut.phase_q), 32'd1);
    tick(18);
    check_eq("rerun halt early", 32'(halt), 32'd0);
    tick(1);
    check_eq("rerun halt set", 32'(halt), 32'd1);
    check_eq("rerun mem8", 32'(dut.memory_inst.array[8]), 32'h5A);
    tick(4);
    check_eq("halt frozen", 32'(halt), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("halt cleared", 32'(halt), 32'd0);
    tick(1);
    rst = 1'b0;

    // Random programs checked at HLT or after a bounded number of instructions.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      load_prog();
      n_exec = 0;
      hlt = 1'b0;
      while (n_exec < 40) begin
        m_step(hlt);
        if (hlt) break;
        n_exec++;
      end
      do_reset();
      if (hlt) begin
        tick(8 * n_exec + 2);
        check_eq($sformatf("rnd%0d halt early", t), 32'(halt), 32'd0);
        tick(1);
        check_eq($sformatf("rnd%0d halt set", t), 32'(halt), 32'd1);
        tick(3);
        check_eq($sformatf("rnd%0d halt held", t), 32'(halt), 32'd1);
      end else begin
        tick(8 * n_exec - 1);
        check_eq($sformatf("rnd%0d no halt", t), 32'(halt), 32'd0);
      end
      check_eq($sformatf("rnd%0d pc", t), 32'(dut.pc), 32'(m_pc));
      check_eq($sformatf("rnd%0d ac", t), 32'(dut.ac), 32'(m_ac));
      check_mem_all($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
